// File: rtl/async_pkg.sv
// Shared types and helpers for the 4-phase round-robin arbiter.
// Provides the FSM state type, index-width helper and winner pick.
package async_pkg;

    // Upper bound on requesters supported by rr_pick.
    localparam int MAX_SIZE = 32;
    localparam int PICK_W   = 5;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        ACK,
        REL
    } arb_state_t;

    // Index width max(1, clog2(n)).
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // First set bit of req scanning ptr, ptr+1, ... wrapping n-1 -> 0.
    // Returns ptr when req is empty (caller only uses it when req != 0).
    function automatic int rr_pick(
        input logic [MAX_SIZE-1:0] req,
        input int                  ptr,
        input int                  n
    );
        int   idx;
        logic found;
        rr_pick = ptr;
        found   = 1'b0;
        for (int i = 0; i < MAX_SIZE; i++) begin
            idx = ptr + i;
            if (idx >= n) idx = idx - n;
            if (!found && (i < n) && req[idx[PICK_W-1:0]]) begin
                rr_pick = idx;
                found   = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop synchroniser with synchronous clear; stages=0 is a wire.
// Ports: clk, rst (sync, active-high), d (async in), q (synchronised out).
module sync_ff #(
    parameter int width  = 1,
    parameter int stages = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [width-1:0] d,
    output logic [width-1:0] q
);

    generate
        if (stages == 0) begin : g_pass
            logic unused_clk_rst;
            assign unused_clk_rst = clk ^ rst;
            assign q = d;
        end else begin : g_sync
            logic [width-1:0] chain [stages];

            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int i = 0; i < stages; i++) chain[i] <= '0;
                end else begin
                    chain[0] <= d;
                    for (int i = 1; i < stages; i++) chain[i] <= chain[i-1];
                end
            end

            assign q = chain[stages-1];
        end
    endgenerate

endmodule

// File: rtl/arb_rr_4ph.sv
// Round-robin arbiter sharing one 4-phase req/ack channel among requesters.
// Ports: clk, rst (sync, active-high), req_in/ack_in (requester side),
// req_out/ack_out (shared channel), grant_idx (owner), busy (channel owned).
module arb_rr_4ph
    import async_pkg::*;
#(
    parameter  int size        = 4,
    parameter  int sync_stages = 2,
    localparam int IW          = idx_w(size)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [size-1:0] req_in,
    output logic [size-1:0] ack_in,
    output logic            req_out,
    input  logic            ack_out,
    output logic [IW-1:0]   grant_idx,
    output logic            busy
);

    logic [size-1:0] req_s;
    logic            ack_s;
    arb_state_t      state;
    logic [IW-1:0]   ptr;
    logic [IW-1:0]   pick;

    sync_ff #(
        .width  (size),
        .stages (sync_stages)
    ) u_sync_req (
        .clk (clk),
        .rst (rst),
        .d   (req_in),
        .q   (req_s)
    );

    sync_ff #(
        .width  (1),
        .stages (sync_stages)
    ) u_sync_ack (
        .clk (clk),
        .rst (rst),
        .d   (ack_out),
        .q   (ack_s)
    );

    assign pick = IW'(rr_pick(MAX_SIZE'(req_s), int'(ptr), size));

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            req_out   <= 1'b0;
            ack_in    <= '0;
            busy      <= 1'b0;
            grant_idx <= '0;
            ptr       <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (|req_s) begin
                        grant_idx <= pick;
                        req_out   <= 1'b1;
                        busy      <= 1'b1;
                        state     <= REQ;
                    end
                end
                REQ: begin
                    if (ack_s) begin
                        ack_in <= size'(1) << grant_idx;
                        state  <= ACK;
                    end
                end
                ACK: begin
                    // ack_in is one-hot on the owner, so it masks req_s[g].
                    if (!(|(req_s & ack_in))) begin
                        req_out <= 1'b0;
                        state   <= REL;
                    end
                end
                REL: begin
                    if (!ack_s) begin
                        ack_in <= '0;
                        busy   <= 1'b0;
                        // The just-served requester drops to lowest priority.
                        ptr    <= (grant_idx == IW'(size - 1)) ? '0
                                                               : grant_idx + 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

endmodule
